// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small first-word-fall-through FIFO.
// A 2-flop synchroniser cleans up ser_rx. An FSM samples each bit at mid-bit
// and checks the start and stop bits. Accepted bytes are pushed into a
// circular buffer. The buffer uses pointers that are one bit wider than the
// address, so that full and empty can be told apart.
// Optional build macro: UART_RX_PARITY_EN selects 8E1 framing and adds a
// sticky parity_err output.
//
// Pop handshake: rx_valid means the FIFO is not empty and rx_data holds the
// head byte. A pop happens on any rising edge where rx_valid and rx_ready are
// both high. rx_ready is ignored while rx_valid is low.
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 4167,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ser_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          err_clear,
    output logic                          rx_busy,
    output logic [2:0]                    dbg_state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_M1    = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LOAD = 16'(BAUD_DIV - BAUD_DIV / 2);
    localparam logic [AW:0] DEPTH_V   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t       state_q, state_d;
    logic         sync1_q, sync2_q;
    logic [15:0]  timer_q, timer_d;
    logic [2:0]   bit_q, bit_d;
    logic [7:0]   shift_q, shift_d;
    logic         push, frame_set;
    logic         frame_err_q, overrun_err_q;
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [7:0]   mem_q [FIFO_DEPTH];
    logic         rxs, tick, full, pop, do_write, overrun_set;
    logic [AW:0]  count;
`ifdef UART_RX_PARITY_EN
    logic         par_bad_q, par_bad_d, par_set, parity_err_q;
`endif

    assign rxs  = sync2_q;
    assign tick = (timer_q == DIV_M1);

    // Two-flop synchroniser; it resets to the idle-high line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ser_rx;
            sync2_q <= sync1_q;
        end
    end

    // FSM state register and the receive datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next state, bit timer and sampling; raises push and error-set strobes
    always_comb begin
        state_d   = state_q;
        timer_d   = tick ? 16'd0 : timer_q + 16'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_set   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                    timer_d = HALF_LOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rxs, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    par_bad_d = rxs ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (rxs) begin
`ifdef UART_RX_PARITY_EN
                        par_set = par_bad_q;
                        push    = !par_bad_q;
`else
                        push    = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        // A low stop bit only reports a framing error,
                        // even if the parity was also wrong
                        frame_set = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                timer_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs that are decoded from the state
    always_comb begin
        rx_busy     = (state_q != S_IDLE);
        dbg_state_o = state_q;
    end

    assign count       = wr_ptr_q - rd_ptr_q;
    assign full        = (count == DEPTH_V);
    assign pop         = (count != '0) && rx_ready;
    assign do_write    = push && (!full || pop);
    assign overrun_set = push && full && !pop;

    // FIFO pointers; a pop frees a slot, so a push in the same cycle is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; it needs no reset because the pointers gate what is seen
    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    // Sticky error flags; a set event beats err_clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= frame_set   | (frame_err_q   & ~err_clear);
            overrun_err_q <= overrun_set | (overrun_err_q & ~err_clear);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error flag; it follows the same priority as the others
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else        parity_err_q <= par_set | (parity_err_q & ~err_clear);
    end
    assign parity_err = parity_err_q;
`endif

    assign rx_valid    = (count != '0);
    assign rx_data     = rx_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign rx_count    = count;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 UART receiver for the user project. Consumes the serial line driven onto mprj_io[5] by the bench UART's ser_tx.
- Deserialises frames, validates start and stop bits, and buffers received bytes in a small first-word-fall-through FIFO.
- Firmware-side logic pops bytes with a valid/ready handshake. Framing and overrun errors are held in sticky flags.

Parameters:
- BAUD_DIV, 4167, clock cycles per bit (40 MHz / 9600); legal range 8..65535.
- FIFO_DEPTH, 4, FIFO entries; must be a power of two, 2..16.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ser_rx  input  1  serial line; idles high.
- rx_data  output  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  pop request; a pop occurs when rx_valid & rx_ready at a clock edge.
- rx_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
- frame_err  output  1  sticky; set when a stop bit is sampled low.
- overrun_err  output  1  sticky; set when a valid byte arrives while the FIFO is full.
- err_clear  input  1  synchronous clear of both sticky flags.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - clk and rst_n are the only clock and reset; reset is asynchronous active-low.
  - Reset values: rx_data=0, rx_valid=0, rx_count=0, frame_err=0, overrun_err=0, rx_busy=0.
  - State goes to IDLE, the FIFO pointers go to 0, and both synchroniser flops are set to 1.
  - Reset asserted mid-frame discards the partial frame and all FIFO contents.
- Input path: ser_rx passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- Bit timer: counts 0..BAUD_DIV-1 and reloads on each sample point.
- State machine:
  - IDLE: rxs=0 for one cycle -> START; the timer is loaded so the next sample lands at BAUD_DIV/2 (integer division).
  - START: at half-bit, rxs=1 -> IDLE (glitch rejected, no flag set); rxs=0 -> DATA, bit index 0.
  - DATA: sample every BAUD_DIV cycles, LSB first, into a shift register; after bit 7 -> STOP (or PARITY when the optional feature is enabled).
  - STOP: at the sample point, rxs=1 -> push the byte and go to IDLE. rxs=0 -> set frame_err, discard the byte, go to BREAK.
  - BREAK: stay until rxs=1, then -> IDLE. This prevents a held-low line from producing 0x00 frames.
- Push timing: the byte becomes visible on rx_data/rx_valid on the cycle after the stop-bit sample edge when the FIFO was empty (1-cycle latency).
- FIFO:
  - Circular buffer with a 1-bit-extended pointer; rx_data always shows the head entry.
  - Full with push and no pop: the byte is dropped, existing contents are kept, and overrun_err is set.
  - Full with push and pop in the same cycle: both occur, no overrun, rx_count unchanged.
  - Empty with pop requested: ignored; rx_count never underflows.
  - Pointers wrap modulo FIFO_DEPTH.
- Error flags:
  - err_clear wins over a set event in the same cycle? No: a set event in the same cycle takes priority, so the flag stays 1.
  - Flags affect nothing else; reception continues.
- rx_busy=1 in START, DATA, PARITY, STOP and BREAK.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Frame is 8E1: an even-parity bit is sampled one BAUD_DIV after bit 7 in a PARITY state, then STOP.
  - A mismatch sets the extra sticky output parity_err, which err_clear also clears; the byte is discarded.
  - Frame error takes precedence: if the stop bit is also low, only frame_err is set.
- When undefined: no PARITY state, no parity_err port, 8N1 only.

Test Plan:
- BAUD_DIV=16. Drive 0x3D (61) in 8N1 form -> exactly 1 cycle after the stop-bit sample: rx_valid=1, rx_data=0x3D, rx_count=1. Pulse rx_ready -> rx_valid=0, rx_count=0.
- Low pulse of 4 cycles on an idle line -> returns to IDLE at the half-bit check; rx_valid=0, frame_err=0, rx_busy back to 0 within 10 cycles.
- Send 0x55 with the stop bit forced low for 40 cycles -> frame_err=1, rx_count=0, BREAK held until the line rises. A following 0xA7 is received correctly. Then err_clear -> frame_err=0.
- With rx_ready=0, send 0x01..0x05 back to back -> rx_count=4, overrun_err=1. Pops return 0x01, 0x02, 0x03, 0x04, then rx_valid=0.
- FIFO full; hold rx_ready=1 on the cycle of the next push (0x99) -> no overrun, rx_count stays 4, and after 4 pops the last byte popped is 0x99.
- Assert rst_n=0 during bit 3 of a frame with 2 bytes buffered -> all outputs return to their reset values immediately. After release, a clean 0xC3 is received.
